spc_ctl: RTL and testbench

SPC_CTL -- requirements
Module: spc_ctl

---
 rtl/spc_ctl.sv | 171 +++++++++++++++++
 tb/tb_spc_ctl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spc_ctl.sv
// rtl/spc_ctl.sv - SPC stack debug access controller with CPU pass-through and depth tracking
module spc_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        halted,
  input  logic        cpu_state_fetch,
  input  logic        cpu_spcnt,
  input  logic        cpu_spush,
  input  logic        cpu_srp,
  input  logic        cpu_swp,
  input  logic [18:0] cpu_spcw,
  output logic        spc_state_fetch,
  output logic        spc_spcnt,
  output logic        spc_spush,
  output logic        spc_srp,
  output logic        spc_swp,
  output logic [18:0] spc_spcw,
  input  logic [18:0] spco,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_op,
  input  logic [18:0] dbg_wdata,
  input  logic        dbg_clr,
  output logic        dbg_ack,
  output logic [18:0] dbg_rdata,
  output logic        cpu_stall,
  output logic [5:0]  depth,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, PUSH, POPD, ACK} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;
  localparam logic [5:0] DEPTH_MAX = 6'd32;

  state_t      state;
  logic        is_pop;
  logic        f_fetch;
  logic        f_spcnt;
  logic        f_spush;
  logic        f_srp;
  logic        f_swp;
  logic [18:0] f_spcw;
  logic        idle;
  logic        stack_step;
  logic        ovf_set;
  logic        unf_set;

  // Debug sequencer; strobes are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      is_pop    <= 1'b0;
      f_fetch   <= 1'b0;
      f_spcnt   <= 1'b0;
      f_spush   <= 1'b0;
      f_srp     <= 1'b0;
      f_swp     <= 1'b0;
      f_spcw    <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      f_fetch <= 1'b0;
      f_spcnt <= 1'b0;
      f_spush <= 1'b0;
      f_srp   <= 1'b0;
      f_swp   <= 1'b0;
      f_spcw  <= '0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_req && halted) begin
            case (dbg_op)
              OP_READ: begin
                state  <= RD;
                f_srp  <= 1'b1;
                is_pop <= 1'b0;
              end
              OP_WRITE: begin
                state  <= WR;
                f_swp  <= 1'b1;
                f_spcw <= dbg_wdata;
              end
              OP_PUSH: begin
                state   <= PUSH;
                f_swp   <= 1'b1;
                f_spcnt <= 1'b1;
                f_spush <= 1'b1;
                f_fetch <= 1'b1;
                f_spcw  <= dbg_wdata;
              end
              default: begin
                state  <= RD;
                f_srp  <= 1'b1;
                is_pop <= 1'b1;
              end
            endcase
          end
        end
        RD: state <= CAP;
        CAP: begin
          // spco now holds the top entry addressed during RD
          dbg_rdata <= spco;
          if (is_pop) begin
            state   <= POPD;
            f_fetch <= 1'b1;
            f_spcnt <= 1'b1;
          end else begin
            state   <= ACK;
            dbg_ack <= 1'b1;
          end
        end
        WR, PUSH, POPD: begin
          state   <= ACK;
          dbg_ack <= 1'b1;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign idle      = (state == IDLE);
  assign cpu_stall = !idle;

  // CPU owns the stack in IDLE; otherwise the sequencer does, silenced while reset is low
  always_comb begin
    if (idle) begin
      spc_state_fetch = cpu_state_fetch;
      spc_spcnt       = cpu_spcnt;
      spc_spush       = cpu_spush;
      spc_srp         = cpu_srp;
      spc_swp         = cpu_swp;
      spc_spcw        = cpu_spcw;
    end else begin
      spc_state_fetch = f_fetch & reset;
      spc_spcnt       = f_spcnt & reset;
      spc_spush       = f_spush & reset;
      spc_srp         = f_srp & reset;
      spc_swp         = f_swp & reset;
      spc_spcw        = reset ? f_spcw : '0;
    end
  end

  assign stack_step = spc_state_fetch & spc_spcnt;
  assign ovf_set    = stack_step & spc_spush & (depth == DEPTH_MAX);
  assign unf_set    = stack_step & !spc_spush & (depth == 6'd0);

  // Saturating occupancy count and sticky error flags; a set event beats a clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (stack_step) begin
        if (spc_spush) begin
          if (depth != DEPTH_MAX) depth <= depth + 6'd1;
        end else begin
          if (depth != 6'd0) depth <= depth - 6'd1;
        end
      end
      ovf <= ovf_set | (ovf & !dbg_clr);
      unf <= unf_set | (unf & !dbg_clr);
    end
  end

endmodule

// File: tb/tb_spc_ctl.sv
// tb/tb_spc_ctl.sv - randomized bench for spc_ctl against an operation-level reference model
module tb_spc_ctl;

  localparam int P_NONE = 0;
  localparam int P_RD   = 1;
  localparam int P_CAP  = 2;
  localparam int P_WR   = 3;
  localparam int P_PUSH = 4;
  localparam int P_POPD = 5;
  localparam int P_ACK  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halted = 1'b0;
  logic        cpu_state_fetch = 1'b0;
  logic        cpu_spcnt = 1'b0;
  logic        cpu_spush = 1'b0;
  logic        cpu_srp = 1'b0;
  logic        cpu_swp = 1'b0;
  logic [18:0] cpu_spcw = '0;
  logic        spc_state_fetch;
  logic        spc_spcnt;
  logic        spc_spush;
  logic        spc_srp;
  logic        spc_swp;
  logic [18:0] spc_spcw;
  logic [18:0] spco = '0;
  logic        dbg_req = 1'b0;
  logic [1:0]  dbg_op = 2'b00;
  logic [18:0] dbg_wdata = '0;
  logic        dbg_clr = 1'b0;
  logic        dbg_ack;
  logic [18:0] dbg_rdata;
  logic        cpu_stall;
  logic [5:0]  depth;
  logic        ovf;
  logic        unf;

  spc_ctl dut (
    .clk(clk), .reset(reset), .halted(halted),
    .cpu_state_fetch(cpu_state_fetch), .cpu_spcnt(cpu_spcnt), .cpu_spush(cpu_spush),
    .cpu_srp(cpu_srp), .cpu_swp(cpu_swp), .cpu_spcw(cpu_spcw),
    .spc_state_fetch(spc_state_fetch), .spc_spcnt(spc_spcnt), .spc_spush(spc_spush),
    .spc_srp(spc_srp), .spc_swp(spc_swp), .spc_spcw(spc_spcw),
    .spco(spco), .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_wdata(dbg_wdata),
    .dbg_clr(dbg_clr), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .cpu_stall(cpu_stall), .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase sequence each debug op walks through after being accepted
  function automatic int op_len(input int op);
    case (op)
      0: return 3;
      1: return 2;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_of(input int op, input int step);
    case (op)
      0: return (step == 0) ? P_RD : (step == 1) ? P_CAP : P_ACK;
      1: return (step == 0) ? P_WR : P_ACK;
      2: return (step == 0) ? P_PUSH : P_ACK;
      default: return (step == 0) ? P_RD : (step == 1) ? P_CAP : (step == 2) ? P_POPD : P_ACK;
    endcase
  endfunction

  // {state_fetch, spcnt, spush, srp, swp} driven to the stack in each phase
  function automatic logic [4:0] strobes_of(input int ph);
    case (ph)
      P_RD:    return 5'b00010;
      P_WR:    return 5'b00001;
      P_PUSH:  return 5'b11101;
      P_POPD:  return 5'b11000;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference model state
  bit          m_busy = 0;
  int          m_op = 0;
  int          m_step = 0;
  int          m_depth = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  logic [18:0] m_rdata = '0;
  logic [18:0] m_wdata = '0;
  bit          m_ack_now = 0;

  // Emulated SPC stack attached to the DUT outputs
  logic [18:0] mem [32];
  logic [4:0]  sp = '0;
  logic [4:0]  snap_s = '0;
  logic [18:0] snap_w = '0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end

  // Advance model and stack emulation on each rising edge
  always @(posedge clk) begin
    logic [4:0] s;
    bit oset;
    bit uset;
    if (!reset) begin
      m_busy  = 0;
      m_depth = 0;
      m_ovf   = 0;
      m_unf   = 0;
      m_rdata = '0;
    end else begin
      if (!m_busy) s = {cpu_state_fetch, cpu_spcnt, cpu_spush, cpu_srp, cpu_swp};
      else s = strobes_of(phase_of(m_op, m_step));
      oset = 0;
      uset = 0;
      if (s[4] && s[3]) begin
        if (s[2]) begin
          if (m_depth == 32) oset = 1; else m_depth++;
        end else begin
          if (m_depth == 0) uset = 1; else m_depth--;
        end
      end
      m_ovf = oset || (m_ovf && !dbg_clr);
      m_unf = uset || (m_unf && !dbg_clr);
      if (m_busy && phase_of(m_op, m_step) == P_CAP) m_rdata = spco;
      if (!m_busy) begin
        if (dbg_req && halted) begin
          m_busy  = 1;
          m_op    = int'(dbg_op);
          m_step  = 0;
          m_wdata = dbg_wdata;
        end
      end else begin
        m_step++;
        if (m_step == op_len(m_op)) m_busy = 0;
      end
    end
    if (snap_s[1]) spco <= mem[sp - 5'd1];
    if (snap_s[4] && snap_s[3]) begin
      if (snap_s[2]) begin
        if (snap_s[0]) mem[sp] = snap_w;
        sp = sp + 5'd1;
      end else begin
        sp = sp - 5'd1;
      end
    end else if (snap_s[0]) begin
      mem[sp - 5'd1] = snap_w;
    end
  end

  // Compare DUT outputs with the model every cycle
  always @(negedge clk) begin
    logic [4:0]  es;
    logic [18:0] ew;
    int          ph;
    snap_s = {spc_state_fetch, spc_spcnt, spc_spush, spc_srp, spc_swp};
    snap_w = spc_spcw;
    ph = m_busy ? phase_of(m_op, m_step) : P_NONE;
    if (!m_busy) begin
      es = {cpu_state_fetch, cpu_spcnt, cpu_spush, cpu_srp, cpu_swp};
      ew = cpu_spcw;
    end else begin
      es = reset ? strobes_of(ph) : 5'b0;
      ew = (reset && (ph == P_WR || ph == P_PUSH)) ? m_wdata : '0;
    end
    chk("spc_strobes", 32'(snap_s), 32'(es));
    chk("spc_spcw", 32'(spc_spcw), 32'(ew));
    chk("cpu_stall", 32'(cpu_stall), 32'(m_busy));
    chk("dbg_ack", 32'(dbg_ack), 32'(ph == P_ACK));
    chk("depth", 32'(depth), 32'(m_depth));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
    chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rdata));
    m_ack_now = (ph == P_ACK);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic [4:0] s, input logic [18:0] w);
    {cpu_state_fetch, cpu_spcnt, cpu_spush, cpu_srp, cpu_swp} = s;
    cpu_spcw = w;
  endtask

  // Issue a debug op and measure cycles from the accept edge to dbg_ack
  task automatic do_op(input logic [1:0] op, input logic [18:0] wd, input int lat, input string nm);
    int n;
    bit got;
    dbg_op    = op;
    dbg_wdata = wd;
    dbg_req   = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (dbg_ack === 1'b1) got = 1;
    end
    chk(nm, 32'(n), 32'(lat));
    tick();
    dbg_req = 1'b0;
  endtask

  initial begin
    #1;
    repeat (3) tick();
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    reset  = 1'b1;
    halted = 1'b1;
    tick();

    do_op(2'b10, 19'h12345, 2, "push_latency");
    chk("push_depth", 32'(depth), 32'd1);
    do_op(2'b00, 19'h0, 3, "read_latency");
    chk("read_rdata", 32'(dbg_rdata), 32'h12345);
    do_op(2'b11, 19'h0, 4, "pop_latency");
    chk("pop_rdata", 32'(dbg_rdata), 32'h12345);
    chk("pop_depth", 32'(depth), 32'd0);
    do_op(2'b11, 19'h0, 4, "pop_empty_latency");
    chk("pop_empty_unf", 32'(unf), 32'd1);
    chk("pop_empty_depth", 32'(depth), 32'd0);
    dbg_clr = 1'b1;
    tick();
    dbg_clr = 1'b0;
    chk("unf_cleared", 32'(unf), 32'd0);

    halted = 1'b0;
    reset  = 1'b0;
    tick();
    reset = 1'b1;
    set_cpu(5'b11101, 19'h00abc);
    repeat (33) tick();
    chk("cpu_push_depth", 32'(depth), 32'd32);
    chk("cpu_push_ovf", 32'(ovf), 32'd1);
    dbg_clr = 1'b1;
    tick();
    chk("clr_vs_set_ovf", 32'(ovf), 32'd1);
    chk("sat_depth", 32'(depth), 32'd32);
    set_cpu(5'b00000, 19'h0);
    tick();
    dbg_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    dbg_op  = 2'b10;
    dbg_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cpu(5'($urandom), 19'($urandom));
      tick();
      chk("not_halted_stall", 32'(cpu_stall), 32'd0);
      chk("not_halted_pass", 32'({spc_srp, spc_swp, spc_spcw}), 32'({cpu_srp, cpu_swp, cpu_spcw}));
    end
    dbg_req = 1'b0;
    set_cpu(5'b00000, 19'h0);

    halted = 1'b1;
    reset  = 1'b0;
    tick();
    reset = 1'b1;
    do_op(2'b10, 19'h00777, 2, "push2_latency");
    chk("push2_depth", 32'(depth), 32'd1);
    dbg_op  = 2'b00;
    dbg_req = 1'b1;
    @(posedge clk);
    tick();
    chk("in_cap_stall", 32'(cpu_stall), 32'd1);
    reset   = 1'b0;
    dbg_req = 1'b0;
    tick();
    chk("abort_stall", 32'(cpu_stall), 32'd0);
    chk("abort_ack", 32'(dbg_ack), 32'd0);
    chk("abort_depth", 32'(depth), 32'd0);
    reset = 1'b1;
    tick();
    chk("abort_no_late_ack", 32'(dbg_ack), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      set_cpu(5'($urandom) & 5'($urandom), 19'($urandom));
      halted  = ($urandom_range(0, 4) != 0);
      dbg_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 99) != 0);
      if (dbg_req && m_ack_now) begin
        dbg_req = 1'b0;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_op    = 2'($urandom);
        dbg_wdata = 19'($urandom);
        dbg_req   = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
